// File: rtl/cv32e40x_xif_result_buffer_if.sv
// Handshake bundle between the AES32 FU, the XIF commit channel and the XIF
// result channel, as seen by cv32e40x_xif_result_buffer.
//   fu_*      : FU result push (valid/ready, id, rd, data)
//   commit_*  : XIF commit strobe with kill flag
//   result_*  : XIF result channel (valid/ready, id, rd, data, we)
//   occupancy_o : number of queued entries
// slave modport = the buffer; master modport = whatever drives it.
interface cv32e40x_xif_result_buffer_if #(
  parameter int DEPTH       = 2,
  parameter int X_ID_WIDTH  = 4,
  parameter int X_RFW_WIDTH = 32
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic                   fu_valid_i;
  logic                   fu_ready_o;
  logic [X_ID_WIDTH-1:0]  fu_id_i;
  logic [4:0]             fu_rd_i;
  logic [X_RFW_WIDTH-1:0] fu_data_i;

  logic                   commit_valid_i;
  logic [X_ID_WIDTH-1:0]  commit_id_i;
  logic                   commit_kill_i;

  logic                   result_valid_o;
  logic                   result_ready_i;
  logic [X_ID_WIDTH-1:0]  result_id_o;
  logic [4:0]             result_rd_o;
  logic [X_RFW_WIDTH-1:0] result_data_o;
  logic                   result_we_o;

  logic [OCC_W-1:0]       occupancy_o;

  modport slave (
    input  fu_valid_i, fu_id_i, fu_rd_i, fu_data_i,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    input  result_ready_i,
    output fu_ready_o, result_valid_o, result_id_o, result_rd_o,
    output result_data_o, result_we_o, occupancy_o
  );

  modport master (
    output fu_valid_i, fu_id_i, fu_rd_i, fu_data_i,
    output commit_valid_i, commit_id_i, commit_kill_i,
    output result_ready_i,
    input  fu_ready_o, result_valid_o, result_id_o, result_rd_o,
    input  result_data_o, result_we_o, occupancy_o
  );
endinterface

// File: rtl/cv32e40x_xif_result_buffer.sv
// In-order result queue between the AES32 FU output and the XIF result channel.
// The FU pushes {id, rd, data} whenever there is room; a per-id scoreboard
// records commit/kill independently of result arrival. The head entry is
// emitted once committed, or silently dropped once killed.
// Ports:
//   clk_i  : clock
//   rst_n  : asynchronous active-low reset
//   xif    : slave side of cv32e40x_xif_result_buffer_if (FU push, commit
//            strobe, result channel, occupancy)
module cv32e40x_xif_result_buffer #(
  parameter int DEPTH       = 2,
  parameter int X_ID_WIDTH  = 4,
  parameter int X_RFW_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_n,
  cv32e40x_xif_result_buffer_if.slave   xif
);
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int NID = 2**X_ID_WIDTH;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [4:0]             rd;
    logic [X_RFW_WIDTH-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [NID-1:0]  cmt, kil, cmt_nxt, kil_nxt;

  entry_t          head;
  logic            empty, full, head_cmt, head_kil;
  logic            res_vld, res_pop, drop, push, pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign head     = mem[rd_ptr[AW-1:0]];
  assign head_cmt = cmt[head.id];
  assign head_kil = kil[head.id];

  // Commit takes priority over kill at the head so a presented result can
  // never be retracted by a later strobe on the same id.
  assign res_vld = !empty && head_cmt;
  assign drop    = !empty && !head_cmt && head_kil;
  assign res_pop = res_vld && xif.result_ready_i;
  assign pop     = res_pop || drop;

  // Ready comes from registered pointers only; no path from result_ready_i.
  assign push    = xif.fu_valid_i && !full;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= '{id: xif.fu_id_i, rd: xif.fu_rd_i, data: xif.fu_data_i};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Clear on pop first, then apply the incoming strobe: a new commit/kill for
  // a reused id in the same cycle survives the clear.
  always_comb begin
    cmt_nxt = cmt;
    kil_nxt = kil;
    if (res_pop) cmt_nxt[head.id] = 1'b0;
    if (drop)    kil_nxt[head.id] = 1'b0;
    if (xif.commit_valid_i) begin
      if (xif.commit_kill_i) kil_nxt[xif.commit_id_i] = 1'b1;
      else                   cmt_nxt[xif.commit_id_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cmt <= '0;
      kil <= '0;
    end else begin
      cmt <= cmt_nxt;
      kil <= kil_nxt;
    end
  end

  // Head fields come straight from storage; storage resets to zero so the
  // outputs read zero out of reset.
  assign xif.fu_ready_o     = !full;
  assign xif.result_valid_o = res_vld;
  assign xif.result_id_o    = head.id;
  assign xif.result_rd_o    = head.rd;
  assign xif.result_data_o  = head.data;
  assign xif.result_we_o    = 1'b1;
  assign xif.occupancy_o    = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_cv32e40x_xif_result_buffer.sv
module tb_cv32e40x_xif_result_buffer;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cv32e40x_xif_result_buffer_if #(.DEPTH(2), .X_ID_WIDTH(4), .X_RFW_WIDTH(32)) xif ();

  cv32e40x_xif_result_buffer #(.DEPTH(2), .X_ID_WIDTH(4), .X_RFW_WIDTH(32)) dut (
    .clk_i (clk),
    .rst_n (rst_n),
    .xif   (xif.slave)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // All driving and sampling happens on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fu(input logic v, input logic [3:0] id, input logic [4:0] rd, input logic [31:0] d);
    xif.fu_valid_i = v;
    xif.fu_id_i    = id;
    xif.fu_rd_i    = rd;
    xif.fu_data_i  = d;
  endtask

  task automatic cm(input logic v, input logic [3:0] id, input logic k);
    xif.commit_valid_i = v;
    xif.commit_id_i    = id;
    xif.commit_kill_i  = k;
  endtask

  initial begin
    int p, got, cid;
    logic cpend, acc;

    rst_n = 1'b0;
    fu(1'b0, 4'd0, 5'd0, 32'd0);
    cm(1'b0, 4'd0, 1'b0);
    xif.result_ready_i = 1'b1;
    step();
    step();
    // reset state
    chk("rst_occ",   xif.occupancy_o, 0);
    chk("rst_valid", xif.result_valid_o, 0);
    chk("rst_ready", xif.fu_ready_o, 1);
    chk("rst_id",    xif.result_id_o, 0);
    chk("rst_rd",    xif.result_rd_o, 0);
    chk("rst_data",  xif.result_data_o, 0);
    chk("rst_we",    xif.result_we_o, 1);
    rst_n = 1'b1;
    step();

    // 1: push id3, commit two cycles later
    fu(1'b1, 4'd3, 5'd5, 32'hDEADBEEF);
    step();
    fu(1'b0, 4'd0, 5'd0, 32'd0);
    chk("t1_occ1",   xif.occupancy_o, 1);
    chk("t1_wait",   xif.result_valid_o, 0);
    step();
    chk("t1_wait2",  xif.result_valid_o, 0);
    cm(1'b1, 4'd3, 1'b0);
    step();
    cm(1'b0, 4'd0, 1'b0);
    chk("t1_valid",  xif.result_valid_o, 1);
    chk("t1_id",     xif.result_id_o, 3);
    chk("t1_rd",     xif.result_rd_o, 5);
    chk("t1_data",   xif.result_data_o, 32'hDEADBEEF);
    step();
    chk("t1_occ0",   xif.occupancy_o, 0);
    chk("t1_vld0",   xif.result_valid_o, 0);

    // 2: commit before push
    cm(1'b1, 4'd7, 1'b0);
    step();
    cm(1'b0, 4'd0, 1'b0);
    chk("t2_early",  xif.result_valid_o, 0);
    fu(1'b1, 4'd7, 5'd9, 32'h1234);
    step();
    fu(1'b0, 4'd0, 5'd0, 32'd0);
    chk("t2_valid",  xif.result_valid_o, 1);
    chk("t2_id",     xif.result_id_o, 7);
    chk("t2_data",   xif.result_data_o, 32'h1234);
    step();
    chk("t2_occ0",   xif.occupancy_o, 0);

    // 3: kill id1, commit id2
    fu(1'b1, 4'd1, 5'd1, 32'h1111);
    step();
    fu(1'b1, 4'd2, 5'd2, 32'h2222);
    step();
    fu(1'b0, 4'd0, 5'd0, 32'd0);
    chk("t3_occ2",   xif.occupancy_o, 2);
    chk("t3_vld0",   xif.result_valid_o, 0);
    cm(1'b1, 4'd1, 1'b1);
    step();
    chk("t3_kill_occ", xif.occupancy_o, 2);
    chk("t3_kill_vld", xif.result_valid_o, 0);
    cm(1'b1, 4'd2, 1'b0);
    step();
    cm(1'b0, 4'd0, 1'b0);
    chk("t3_occ1",   xif.occupancy_o, 1);
    chk("t3_valid",  xif.result_valid_o, 1);
    chk("t3_id",     xif.result_id_o, 2);
    chk("t3_data",   xif.result_data_o, 32'h2222);
    step();
    chk("t3_occ0",   xif.occupancy_o, 0);
    chk("t3_vld_end", xif.result_valid_o, 0);

    // 4: full with stalled result channel
    xif.result_ready_i = 1'b0;
    fu(1'b1, 4'd4, 5'd4, 32'h4444);
    step();
    fu(1'b1, 4'd5, 5'd6, 32'h5555);
    cm(1'b1, 4'd4, 1'b0);
    step();
    cm(1'b0, 4'd0, 1'b0);
    fu(1'b1, 4'd9, 5'd9, 32'h9999);  // must be blocked while full
    for (int i = 0; i < 5; i++) begin
      chk("t4_full",  xif.fu_ready_o, 0);
      chk("t4_occ",   xif.occupancy_o, 2);
      chk("t4_valid", xif.result_valid_o, 1);
      chk("t4_id",    xif.result_id_o, 4);
      chk("t4_rd",    xif.result_rd_o, 4);
      chk("t4_data",  xif.result_data_o, 32'h4444);
      step();
    end
    fu(1'b0, 4'd0, 5'd0, 32'd0);
    xif.result_ready_i = 1'b1;
    step();
    chk("t4_occ1",   xif.occupancy_o, 1);
    chk("t4_ready",  xif.fu_ready_o, 1);
    chk("t4_head5",  xif.result_valid_o, 0);
    cm(1'b1, 4'd5, 1'b0);
    step();
    cm(1'b0, 4'd0, 1'b0);
    chk("t4_v5",     xif.result_valid_o, 1);
    chk("t4_id5",    xif.result_id_o, 5);
    chk("t4_data5",  xif.result_data_o, 32'h5555);
    step();
    chk("t4_occ0",   xif.occupancy_o, 0);

    // 5: streaming with wrap, commits lag the push by one cycle
    p = 0; got = 0; cid = 0; cpend = 1'b0;
    for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
      fu(p < 10, 4'(p), 5'(p + 1), 32'hA500_0000 + 32'(p));
      cm(cpend, 4'(cid), 1'b0);
      acc = xif.fu_valid_i && xif.fu_ready_o;
      if (xif.result_valid_o) begin
        chk("t5_id",   xif.result_id_o, 64'(got));
        chk("t5_rd",   xif.result_rd_o, 64'(got + 1));
        chk("t5_data", xif.result_data_o, 64'(32'hA500_0000 + 32'(got)));
        got++;
      end
      @(posedge clk);
      cpend = acc;
      cid   = p;
      if (acc) p++;
      @(negedge clk);
    end
    fu(1'b0, 4'd0, 5'd0, 32'd0);
    cm(1'b0, 4'd0, 1'b0);
    chk("t5_count",  64'(got), 10);
    chk("t5_occ0",   xif.occupancy_o, 0);

    // 6: reset with two queued entries
    xif.result_ready_i = 1'b0;
    fu(1'b1, 4'd10, 5'd10, 32'hAAAA);
    step();
    fu(1'b1, 4'd11, 5'd11, 32'hBBBB);
    cm(1'b1, 4'd10, 1'b0);
    step();
    fu(1'b0, 4'd0, 5'd0, 32'd0);
    cm(1'b1, 4'd11, 1'b0);
    step();
    cm(1'b0, 4'd0, 1'b0);
    chk("t6_pre_vld", xif.result_valid_o, 1);
    chk("t6_pre_occ", xif.occupancy_o, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", xif.result_valid_o, 0);
    chk("t6_rst_occ", xif.occupancy_o, 0);
    chk("t6_rst_rdy", xif.fu_ready_o, 1);
    chk("t6_rst_data", xif.result_data_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    xif.result_ready_i = 1'b1;
    step();
    chk("t6_post_vld", xif.result_valid_o, 0);
    chk("t6_post_occ", xif.occupancy_o, 0);
    // stale commit of id 11 must be gone
    fu(1'b1, 4'd11, 5'd11, 32'hCCCC);
    step();
    fu(1'b0, 4'd0, 5'd0, 32'd0);
    chk("t6_stale_vld", xif.result_valid_o, 0);
    chk("t6_stale_occ", xif.occupancy_o, 1);
    cm(1'b1, 4'd11, 1'b1);
    step();
    cm(1'b0, 4'd0, 1'b0);
    chk("t6_drop_vld", xif.result_valid_o, 0);
    step();
    chk("t6_drop_occ", xif.occupancy_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
